// File: rtl/frame_parser.sv
// frame_parser: consumes length-prefixed frames [LEN][payload x LEN][CHK]
// from a byte FIFO with one-cycle read latency. Payload bytes are forwarded
// on pl_*, and each completed frame reports its length, checksum verdict and
// a saturating count of bad frames.
module frame_parser #(
   parameter int DATA_W = 8,
   parameter int ERR_W  = 8
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              en,
   input  logic              empty,
   input  logic [DATA_W-1:0] data_out,
   input  logic              data_out_valid,
   output logic              rd,
   output logic [DATA_W-1:0] pl_data,
   output logic              pl_valid,
   output logic              pl_last,
   output logic              frame_done,
   output logic              frame_ok,
   output logic [DATA_W-1:0] frame_len,
   output logic [ERR_W-1:0]  err_cnt
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PAYLOAD = 2'd1;
   localparam logic [1:0] CHECK   = 2'd2;

   localparam logic [DATA_W-1:0] ONE_BYTE = {{(DATA_W-1){1'b0}}, 1'b1};
   localparam logic [DATA_W:0]   ONE_REQ  = {{DATA_W{1'b0}}, 1'b1};

   logic [1:0]        state;
   // One extra bit so that LEN = all-ones still yields LEN+1 requests.
   logic [DATA_W:0]   req_left;
   logic [DATA_W-1:0] rx_left;
   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] len;
   // The FIFO answers exactly one cycle after rd, so a read issued last
   // cycle is the only thing that makes returning data legitimate.
   logic              rd_q;
   logic              accept;

   assign rd     = en & ~empty & (req_left != '0) & ~clear;
   assign accept = data_out_valid & rd_q;

   // Request accounting and frame-structure FSM.
   always_ff @(posedge clk) begin
      if (clear) begin
         state    <= IDLE;
         req_left <= ONE_REQ;
         rx_left  <= '0;
         sum      <= '0;
         len      <= '0;
         rd_q     <= 1'b0;
      end else begin
         rd_q <= rd;
         if (rd) begin
            req_left <= req_left - ONE_REQ;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  len      <= data_out;
                  sum      <= data_out;
                  rx_left  <= data_out;
                  req_left <= {1'b0, data_out} + ONE_REQ;
                  state    <= (data_out == '0) ? CHECK : PAYLOAD;
               end
            end
            PAYLOAD: begin
               if (accept) begin
                  sum     <= sum + data_out;
                  rx_left <= rx_left - ONE_BYTE;
                  if (rx_left == ONE_BYTE) begin
                     state <= CHECK;
                  end
               end
            end
            CHECK: begin
               if (accept) begin
                  req_left <= ONE_REQ;
                  state    <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Registered payload forwarding and per-frame result reporting.
   always_ff @(posedge clk) begin
      if (clear) begin
         pl_data    <= '0;
         pl_valid   <= 1'b0;
         pl_last    <= 1'b0;
         frame_done <= 1'b0;
         frame_ok   <= 1'b0;
         frame_len  <= '0;
         err_cnt    <= '0;
      end else begin
         pl_valid   <= 1'b0;
         pl_last    <= 1'b0;
         frame_done <= 1'b0;
         if (accept && (state == PAYLOAD)) begin
            pl_data  <= data_out;
            pl_valid <= 1'b1;
            pl_last  <= (rx_left == ONE_BYTE);
         end
         if (accept && (state == CHECK)) begin
            frame_done <= 1'b1;
            frame_ok   <= (data_out == sum);
            frame_len  <= len;
            if ((data_out != sum) && (err_cnt != '1)) begin
               err_cnt <= err_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_frame_parser.sv
// tb_frame_parser: drives frame_parser from a behavioural one-cycle-latency
// FIFO. Stimulus pushes frame bytes and the expected payload/frame results
// into scoreboard queues; a monitor pops and compares whenever the DUT
// presents pl_valid or frame_done.
module tb_frame_parser;

   localparam int DATA_W = 8;
   localparam int ERR_W  = 8;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } pl_t;

   typedef struct packed {
      logic       ok;
      logic [7:0] len;
      logic [7:0] err;
   } fr_t;

   logic              clk = 1'b0;
   logic              clear = 1'b1;
   logic              en = 1'b1;
   logic              empty;
   logic [DATA_W-1:0] data_out = '0;
   logic              data_out_valid = 1'b0;
   logic              rd;
   logic [DATA_W-1:0] pl_data;
   logic              pl_valid;
   logic              pl_last;
   logic              frame_done;
   logic              frame_ok;
   logic [DATA_W-1:0] frame_len;
   logic [ERR_W-1:0]  err_cnt;

   logic       force_empty = 1'b0;
   logic       fifo_empty_r = 1'b1;
   logic       inject = 1'b0;
   logic       mon_on = 1'b0;
   logic [7:0] fifo_q[$];
   logic [7:0] pending_q[$];
   logic [7:0] pay[$];
   pl_t        pl_exp[$];
   fr_t        fr_exp[$];
   pl_t        mp;
   fr_t        mf;

   int checks = 0;
   int fails = 0;
   int rd_count = 0;
   int pl_count = 0;
   int exp_err = 0;
   int rd_base;
   int pl_base;

   assign empty = force_empty | fifo_empty_r;

   frame_parser #(.DATA_W(DATA_W), .ERR_W(ERR_W)) dut (
      .clk(clk),
      .clear(clear),
      .en(en),
      .empty(empty),
      .data_out(data_out),
      .data_out_valid(data_out_valid),
      .rd(rd),
      .pl_data(pl_data),
      .pl_valid(pl_valid),
      .pl_last(pl_last),
      .frame_done(frame_done),
      .frame_ok(frame_ok),
      .frame_len(frame_len),
      .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural FIFO: data for a read appears one cycle after rd.
   always @(posedge clk) begin
      if (rd && (fifo_q.size() > 0)) begin
         data_out       <= fifo_q.pop_front();
         data_out_valid <= 1'b1;
      end else if (inject) begin
         data_out       <= 8'h07;
         data_out_valid <= 1'b1;
      end else begin
         data_out_valid <= 1'b0;
      end
      fifo_empty_r <= (fifo_q.size() == 0);
      if (rd) begin
         rd_count <= rd_count + 1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compares DUT outputs against the scoreboard queues.
   always @(negedge clk) begin
      if (mon_on) begin
         if (empty) begin
            checkOutput("rd_while_empty", {31'd0, rd}, 32'd0);
         end
         if (pl_valid) begin
            pl_count++;
            if (pl_exp.size() == 0) begin
               checkOutput("pl_unexpected", 32'd1, 32'd0);
            end else begin
               mp = pl_exp.pop_front();
               checkOutput("pl_data", {24'd0, pl_data}, {24'd0, mp.data});
               checkOutput("pl_last", {31'd0, pl_last}, {31'd0, mp.last});
            end
         end
         if (frame_done) begin
            if (fr_exp.size() == 0) begin
               checkOutput("frame_unexpected", 32'd1, 32'd0);
            end else begin
               mf = fr_exp.pop_front();
               checkOutput("frame_ok", {31'd0, frame_ok}, {31'd0, mf.ok});
               checkOutput("frame_len", {24'd0, frame_len}, {24'd0, mf.len});
               checkOutput("err_cnt", {24'd0, err_cnt}, {24'd0, mf.err});
            end
         end
      end
   end

   // Frame from pay[] plus chk; the first now_cnt bytes go to the FIFO now
   // (all if negative), the rest wait in pending_q.
   task automatic applyStimulus(input logic [7:0] chk, input int now_cnt);
      logic [7:0] bytes[$];
      logic [7:0] sum;
      logic [7:0] len;
      pl_t        p;
      fr_t        f;
      len = 8'(pay.size());
      sum = len;
      bytes.push_back(len);
      for (int i = 0; i < pay.size(); i++) begin
         bytes.push_back(pay[i]);
         sum    = sum + pay[i];
         p.data = pay[i];
         p.last = (i == pay.size() - 1);
         pl_exp.push_back(p);
      end
      bytes.push_back(chk);
      f.ok = (chk == sum);
      if (!f.ok && exp_err < 255) exp_err++;
      f.len = len;
      f.err = 8'(exp_err);
      fr_exp.push_back(f);
      for (int i = 0; i < bytes.size(); i++) begin
         if (now_cnt < 0 || i < now_cnt) fifo_q.push_back(bytes[i]);
         else pending_q.push_back(bytes[i]);
      end
   endtask

   task automatic releasePending();
      while (pending_q.size() > 0) fifo_q.push_back(pending_q.pop_front());
   endtask

   task automatic waitDrain(input int budget, input string name);
      int n = 0;
      while ((fifo_q.size() != 0 || pl_exp.size() != 0 || fr_exp.size() != 0 || data_out_valid)
             && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, {31'd0, (n < budget)}, 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic doReset(input logic with_inject);
      clear = 1'b1;
      en    = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("rst_rd", {31'd0, rd}, 32'd0);
      checkOutput("rst_pl_valid", {31'd0, pl_valid}, 32'd0);
      checkOutput("rst_pl_data", {24'd0, pl_data}, 32'd0);
      checkOutput("rst_pl_last", {31'd0, pl_last}, 32'd0);
      checkOutput("rst_frame_done", {31'd0, frame_done}, 32'd0);
      checkOutput("rst_frame_ok", {31'd0, frame_ok}, 32'd0);
      checkOutput("rst_frame_len", {24'd0, frame_len}, 32'd0);
      checkOutput("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      fifo_q.delete();
      pending_q.delete();
      exp_err = 0;
      inject  = with_inject;
      @(negedge clk);
      inject = 1'b0;
      clear  = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // A byte in the FIFO during reset makes the rd-during-clear check real.
      fifo_q.push_back(8'hAA);
      @(negedge clk);
      mon_on = 1'b1;
      doReset(1'b0);

      // Good 3-byte frame.
      rd_base = rd_count; pl_base = pl_count;
      pay = '{8'h0A, 8'h0B, 8'h0C};
      applyStimulus(8'h24, -1);
      waitDrain(100, "t1_drain");
      checkOutput("t1_rd_pulses", rd_count - rd_base, 32'd5);
      checkOutput("t1_pl_pulses", pl_count - pl_base, 32'd3);
      checkOutput("t1_frame_len", {24'd0, frame_len}, 32'd3);
      checkOutput("t1_err_cnt", {24'd0, err_cnt}, 32'd0);

      // Bad checksum, then an empty frame.
      applyStimulus(8'h25, -1);
      pay.delete();
      pl_base = pl_count;
      applyStimulus(8'h00, -1);
      waitDrain(100, "t2_drain");
      checkOutput("t2_err_cnt", {24'd0, err_cnt}, 32'd1);
      checkOutput("t2_frame_len", {24'd0, frame_len}, 32'd0);
      checkOutput("t2_frame_ok", {31'd0, frame_ok}, 32'd1);

      // Empty held high, plus a stray data_out_valid with nothing requested.
      force_empty = 1'b1;
      rd_base = rd_count; pl_base = pl_count;
      pay = '{8'h0A, 8'h0B, 8'h0C};
      applyStimulus(8'h24, -1);
      repeat (6) @(negedge clk);
      inject = 1'b1;
      @(negedge clk);
      inject = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("t3_no_rd", rd_count - rd_base, 32'd0);
      checkOutput("t3_no_pl", pl_count - pl_base, 32'd0);
      force_empty = 1'b0;
      waitDrain(100, "t3_drain");
      checkOutput("t3_rd_pulses", rd_count - rd_base, 32'd5);

      // FIFO runs dry after the first payload byte.
      rd_base = rd_count; pl_base = pl_count;
      applyStimulus(8'h24, 2);
      repeat (8) @(negedge clk);
      checkOutput("t4_stall_rd", rd_count - rd_base, 32'd2);
      checkOutput("t4_stall_pl", pl_count - pl_base, 32'd1);
      releasePending();
      waitDrain(100, "t4_drain");
      checkOutput("t4_rd_pulses", rd_count - rd_base, 32'd5);

      // en dropped for 3 cycles mid-frame.
      rd_base = rd_count; pl_base = pl_count;
      applyStimulus(8'h24, -1);
      for (int i = 0; i < 40 && (pl_count - pl_base) < 1; i++) @(negedge clk);
      en = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checkOutput("t4_en_low_rd", {31'd0, rd}, 32'd0);
      end
      en = 1'b1;
      waitDrain(100, "t4_en_drain");
      checkOutput("t4_en_rd_pulses", rd_count - rd_base, 32'd5);

      // Clear after two payload bytes of a LEN=5 frame.
      fifo_q.push_back(8'h05);
      fifo_q.push_back(8'h11);
      fifo_q.push_back(8'h22);
      mp.data = 8'h11; mp.last = 1'b0; pl_exp.push_back(mp);
      mp.data = 8'h22; mp.last = 1'b0; pl_exp.push_back(mp);
      waitDrain(100, "t5_partial_drain");
      doReset(1'b1);
      checkOutput("t5_err_cleared", {24'd0, err_cnt}, 32'd0);
      pay = '{8'hFF};
      applyStimulus(8'h00, -1);
      waitDrain(100, "t5_drain");
      checkOutput("t5_frame_ok", {31'd0, frame_ok}, 32'd1);
      checkOutput("t5_frame_len", {24'd0, frame_len}, 32'd1);

      // 256 bad frames saturate the error counter.
      pay.delete();
      for (int i = 0; i < 256; i++) applyStimulus(8'h01, -1);
      waitDrain(4000, "t6_sat_drain");
      checkOutput("t6_err_sat", {24'd0, err_cnt}, 32'd255);

      // Maximum-length frame: payload 1..255, checksum 0x7F.
      rd_base = rd_count; pl_base = pl_count;
      pay.delete();
      for (int i = 1; i <= 255; i++) pay.push_back(8'(i));
      applyStimulus(8'h7F, -1);
      waitDrain(1000, "t6_max_drain");
      checkOutput("t6_max_rd", rd_count - rd_base, 32'd257);
      checkOutput("t6_max_pl", pl_count - pl_base, 32'd255);
      checkOutput("t6_max_ok", {31'd0, frame_ok}, 32'd1);
      checkOutput("t6_max_len", {24'd0, frame_len}, 32'd255);
      checkOutput("t6_err_held", {24'd0, err_cnt}, 32'd255);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
